mul_div_unit: RTL

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit_if.sv | 21 ++
 rtl/mul_div_unit.sv | 130 +++++++++++++
 2 files changed

// File: rtl/mul_div_unit_if.sv
// rtl/mul_div_unit_if.sv - request/response bundle between the EX stage and mul_div_unit
interface mul_div_unit_if;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;

    modport master (
        output start, funct3, op_a, op_b, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, funct3, op_a, op_b, flush,
        output busy, done, result
    );
endinterface

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative RV32M multiply/divide unit (shift-add / restoring divide)
module mul_div_unit (
    input  logic          clk,
    input  logic          rst_n,
    mul_div_unit_if.slave bus
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t      state, state_nxt;
    logic [4:0]  cnt;
    logic [2:0]  op_q;
    logic [31:0] opnd;
    logic [63:0] acc;
    logic        neg_q;
    logic [31:0] result_q;

    logic        a_signed, b_signed, a_neg, b_neg;
    logic [31:0] a_abs, b_abs;
    logic        fast_zero, fast_ovf, fast;
    logic [31:0] fast_res;
    logic        ready, accept;

    // Operand decode on the request side, evaluated in the accepting cycle
    always_comb begin
        a_signed  = bus.funct3[2] ? ~bus.funct3[0] : (bus.funct3[1:0] != 2'b11);
        b_signed  = bus.funct3[2] ? ~bus.funct3[0] : ~bus.funct3[1];
        a_neg     = a_signed & bus.op_a[31];
        b_neg     = b_signed & bus.op_b[31];
        a_abs     = a_neg ? (32'd0 - bus.op_a) : bus.op_a;
        b_abs     = b_neg ? (32'd0 - bus.op_b) : bus.op_b;
        fast_zero = bus.funct3[2] & (bus.op_b == 32'd0);
        fast_ovf  = bus.funct3[2] & ~bus.funct3[0] &
                    (bus.op_a == 32'h8000_0000) & (bus.op_b == 32'hFFFF_FFFF);
        fast      = fast_zero | fast_ovf;
        if (fast_zero)
            fast_res = bus.funct3[1] ? bus.op_a : 32'hFFFF_FFFF;
        else
            fast_res = bus.funct3[1] ? 32'd0 : 32'h8000_0000;
    end

    assign ready  = (state == IDLE) || (state == DONE);
    assign accept = ready & bus.start & ~bus.flush;

    // One iteration step for each datapath; acc holds {hi, lo} in both modes
    logic [32:0] mul_sum;
    logic [63:0] mul_nxt;
    logic [33:0] div_diff;
    logic [63:0] div_nxt;

    always_comb begin
        mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
        mul_nxt  = {mul_sum, acc[31:1]};
        div_diff = {1'b0, acc[63:31]} - {2'b00, opnd};
        if (div_diff[33])
            div_nxt = {acc[62:31], acc[30:0], 1'b0};
        else
            div_nxt = {div_diff[31:0], acc[30:0], 1'b1};
    end

    logic [63:0] prod;
    logic [31:0] quo_fix, rem_fix, fix_res;

    always_comb begin
        prod    = neg_q ? (64'd0 - acc) : acc;
        quo_fix = neg_q ? (32'd0 - acc[31:0]) : acc[31:0];
        rem_fix = neg_q ? (32'd0 - acc[63:32]) : acc[63:32];
        if (op_q[2])
            fix_res = op_q[1] ? rem_fix : quo_fix;
        else
            fix_res = (op_q[1:0] == 2'b00) ? prod[31:0] : prod[63:32];
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, DONE: begin
                if (accept)
                    state_nxt = fast ? DONE : CALC;
                else
                    state_nxt = IDLE;
            end
            CALC:    if (cnt == 5'd31) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
        if (bus.flush)
            state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= 5'd0;
            op_q     <= 3'd0;
            opnd     <= 32'd0;
            acc      <= 64'd0;
            neg_q    <= 1'b0;
            result_q <= 32'd0;
        end else if (accept) begin
            cnt   <= 5'd0;
            op_q  <= bus.funct3;
            neg_q <= (bus.funct3[2] & bus.funct3[1]) ? a_neg : (a_neg ^ b_neg);
            // Multiply keeps the multiplicand in opnd; divide keeps the divisor there
            opnd  <= bus.funct3[2] ? b_abs : a_abs;
            acc   <= {32'd0, bus.funct3[2] ? a_abs : b_abs};
            if (fast)
                result_q <= fast_res;
        end else if (bus.flush) begin
            cnt <= 5'd0;
        end else if (state == CALC) begin
            acc <= op_q[2] ? div_nxt : mul_nxt;
            cnt <= cnt + 5'd1;
        end else if (state == FIX) begin
            result_q <= fix_res;
        end
    end

    assign bus.busy   = (state == CALC) || (state == FIX);
    assign bus.done   = (state == DONE);
    assign bus.result = result_q;

endmodule
